// File: rtl/exp2_seq.sv
// exp2_seq: sequential fixed-point 2^x. The operand splits into integer n and
// fraction f; 2^f is built by one shared multiply per fraction bit, then scaled by 2^n.
module exp2_seq #(
  parameter int xWI = 2,
  parameter int xWF = 23,
  parameter int cWF = 30,
  parameter int aWF = 30
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [xWI+xWF-1:0] Number,
  output logic               Busy,
  output logic               Done,
  output logic [xWI+xWF-1:0] Pow2
);

  localparam int XW   = xWI + xWF;
  localparam int CW   = cWF + 2;
  localparam int AW   = aWF + 2;
  localparam int PW   = AW + CW;
  localparam int RW   = AW + cWF;
  localparam int CNTW = $clog2(xWF + 1);
  localparam int HP   = 60;
  localparam int BIAS = 1 << (xWI - 1);
  localparam int SW   = AW + 2 * BIAS - 1;
  localparam int RSH  = aWF + BIAS - xWF;
  localparam int QW   = SW + 1 - RSH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;

  localparam logic [AW-1:0]   ACC_ONE  = {2'b01, {aWF{1'b0}}};
  localparam logic [RW-1:0]   MUL_RND  = {{(RW-1){1'b0}}, 1'b1} << (cWF - 1);
  localparam logic [SW:0]     SCL_RND  = {{SW{1'b0}}, 1'b1} << (RSH - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(xWF - 1);

  function automatic logic [127:0] isqrt(input logic [127:0] v);
    logic [127:0] rem;
    logic [127:0] root;
    logic [127:0] bv;
    rem  = v;
    root = 128'd0;
    bv   = 128'd1 << 126;
    for (int k = 0; k < 64; k++) begin
      if (rem >= root + bv) begin
        rem  = rem - (root + bv);
        root = (root >> 1) + bv;
      end else begin
        root = root >> 1;
      end
      bv = bv >> 2;
    end
    return root;
  endfunction

  // K[idx] = 2^(2^-(idx+1)): repeated square roots of 2.0 at HP fraction bits, rounded to cWF.
  function automatic logic [CW-1:0] kconst(input int idx);
    logic [127:0] h;
    logic [127:0] r;
    h = 128'd2 << HP;
    for (int j = 0; j <= idx; j++) begin
      h = isqrt(h << HP);
    end
    r = (h + (128'd1 << (HP - cWF - 1))) >> (HP - cWF);
    return CW'(r);
  endfunction

  logic [CW-1:0] ktab_s [xWF];

  for (genvar g = 0; g < xWF; g++) begin : g_ktab
    localparam logic [CW-1:0] KVAL = kconst(g);
    assign ktab_s[g] = KVAL;
  end

  logic [1:0]      state_r;
  logic            busy_r;
  logic            done_r;
  logic [XW-1:0]   pow2_r;
  logic [AW-1:0]   acc_r;
  logic [CNTW-1:0] cnt_r;
  logic [xWF-1:0]  f_r;
  logic [xWI-1:0]  n_r;

  logic [RW-1:0]   prod_s;
  logic [RW-1:0]   rnd_s;
  logic [AW-1:0]   accn_s;
  logic [xWI-1:0]  shamt_s;
  logic [SW-1:0]   shl_s;
  logic [SW:0]     sum_s;
  logic [QW-1:0]   res_s;
  logic [XW-1:0]   pow_s;

  // acc*K fits in RW bits because both factors are below 2.0.
  assign prod_s = RW'({{CW{1'b0}}, acc_r} * {{AW{1'b0}}, ktab_s[cnt_r]});
  assign rnd_s  = prod_s + MUL_RND;
  assign accn_s = AW'(rnd_s >> cWF);

  // Biasing n by 2^(xWI-1) makes the shift non-negative with a fixed rounding point.
  assign shamt_s = {~n_r[xWI-1], n_r[xWI-2:0]};
  assign shl_s   = {{(SW-AW){1'b0}}, acc_r} << shamt_s;
  assign sum_s   = {1'b0, shl_s} + SCL_RND;
  assign res_s   = QW'(sum_s >> RSH);

  // Saturate results at or above 2^xWI.
  always_comb begin
    pow_s = {XW{1'b0}};
    if (|(res_s >> XW)) begin
      pow_s = {XW{1'b1}};
    end else begin
      pow_s = XW'(res_s);
    end
  end

  // Control FSM with accumulator, bit counter and result register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pow2_r  <= {XW{1'b0}};
      acc_r   <= {AW{1'b0}};
      cnt_r   <= {CNTW{1'b0}};
      f_r     <= {xWF{1'b0}};
      n_r     <= {xWI{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (Start) begin
            n_r     <= Number[XW-1:xWF];
            f_r     <= Number[xWF-1:0];
            acc_r   <= ACC_ONE;
            cnt_r   <= {CNTW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= S_ITER;
          end
        end
        S_ITER: begin
          if (f_r[xWF-1]) begin
            acc_r <= accn_s;
          end
          f_r   <= {f_r[xWF-2:0], 1'b0};
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= S_SCALE;
          end
        end
        S_SCALE: begin
          pow2_r  <= pow_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign Pow2 = pow2_r;

endmodule

// File: tb/tb_exp2_seq.sv
// Directed bench for exp2_seq: exact powers of two, handshake, reset abort,
// and a real-valued 2^x model for tolerance checks.
module tb_exp2_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [24:0] number;
  logic        busy;
  logic        done;
  logic [24:0] pow2;

  int n_cmp = 0;
  int n_bad = 0;

  localparam real SC = 8388608.0;

  exp2_seq dut (
    .Clk    (clk),
    .Rst    (rst),
    .Start  (start),
    .Number (number),
    .Busy   (busy),
    .Done   (done),
    .Pow2   (pow2)
  );

  always #5 clk = ~clk;

  function automatic real model(input logic [24:0] num);
    int  v;
    real x;
    v = $signed(num);
    x = real'(v) / SC;
    return $pow(2.0, x) * SC;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input real obs, input real exp, input real tol);
    real d;
    d = obs - exp;
    if (d < 0.0) d = -d;
    n_cmp++;
    assert (d <= tol) else begin
      n_bad++;
      $error("FAIL %s: observed %f expected %f (tol %f)", tag, obs, exp, tol);
    end
  endtask

  // Starts one operation and waits (bounded) for Done; lat counts the cycle after the accept edge as 1.
  task automatic run_op(input logic [24:0] num, output logic [24:0] res, output int lat, output int bbad);
    number = num;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    bbad  = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) bbad++;
      @(posedge clk); #1;
      lat++;
    end
    res = pow2;
  endtask

  initial begin
    logic [24:0] r;
    logic [24:0] r2;
    logic [24:0] num;
    int          lat;
    int          lat2;
    int          bb;
    int          cnt;
    real         l;

    rst = 1'b0; start = 1'b0; number = 25'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_busy", 32'(busy), 32'd0);
    chk_eq("reset_done", 32'(done), 32'd0);
    chk_eq("reset_pow2", 32'(pow2), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 0.0 -> exactly 1.0, with full latency and Busy profile
    run_op(25'h0000000, r, lat, bb);
    chk_eq("zero_latency", 32'(lat), 32'd25);
    chk_eq("zero_busy_during", 32'(bb), 32'd0);
    chk_eq("zero_busy_in_done", 32'(busy), 32'd0);
    chk_eq("zero_value", 32'(r), 32'h0800000);
    @(posedge clk); #1;
    chk_eq("done_one_cycle", 32'(done), 32'd0);
    chk_eq("pow2_holds", 32'(pow2), 32'h0800000);

    run_op(25'h0800000, r, lat, bb);
    chk_eq("one_value", 32'(r), 32'h1000000);
    run_op(25'h1800000, r, lat, bb);
    chk_eq("minus_one_value", 32'(r), 32'h0400000);
    run_op(25'h1000000, r, lat, bb);
    chk_eq("minus_two_value", 32'(r), 32'h0200000);

    run_op(25'h0400000, r, lat, bb);
    chk_tol("sqrt2_const", real'(r), real'(32'h0B504F3), 2.0);
    chk_tol("sqrt2_model", real'(r), model(25'h0400000), 2.0);

    num = 25'b01_10101000111101011100001;
    run_op(num, r, lat, bb);
    chk_tol("x1p66_model", real'(r), model(num), 2.0);

    run_op(25'h0FFFFFF, r, lat, bb);
    chk_tol("max_const", real'(r), 33554431.0, 2.0);
    chk_tol("max_model", real'(r), model(25'h0FFFFFF), 2.0);

    // Start with a different operand 5 cycles in must be ignored
    number = 25'h0400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    repeat (5) begin @(posedge clk); #1; lat++; end
    number = 25'h0800000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    chk_eq("ignore_latency", 32'(lat), 32'd25);
    chk_tol("ignore_value", real'(pow2), model(25'h0400000), 2.0);
    cnt = 0;
    repeat (30) begin @(posedge clk); #1; if (done === 1'b1) cnt++; end
    chk_eq("ignore_no_second_done", 32'(cnt), 32'd0);

    // Start in the Done cycle is accepted
    run_op(25'h0800000, r, lat, bb);
    run_op(25'h1800000, r2, lat2, bb);
    chk_eq("b2b_first_value", 32'(r), 32'h1000000);
    chk_eq("b2b_latency", 32'(lat2), 32'd25);
    chk_eq("b2b_second_value", 32'(r2), 32'h0400000);

    // Start held high: one result every 25 cycles
    number = 25'h1000000; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    lat2 = 0;
    do begin @(posedge clk); #1; lat2++; end while (done !== 1'b1 && lat2 < 60);
    start = 1'b0;
    chk_eq("held_first_latency", 32'(lat), 32'd25);
    chk_eq("held_period", 32'(lat2), 32'd25);
    chk_eq("held_value", 32'(pow2), 32'h0200000);
    @(posedge clk); #1;

    // Asynchronous reset at cycle 10 aborts the operation
    number = 25'h0C00000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_eq("abort_busy", 32'(busy), 32'd0);
    chk_eq("abort_done", 32'(done), 32'd0);
    chk_eq("abort_pow2", 32'(pow2), 32'd0);
    @(negedge clk); rst = 1'b1;
    cnt = 0;
    repeat (30) begin @(posedge clk); #1; if (done === 1'b1) cnt++; end
    chk_eq("abort_no_stray_done", 32'(cnt), 32'd0);
    run_op(25'h0800000, r, lat, bb);
    chk_eq("after_abort_latency", 32'(lat), 32'd25);
    chk_eq("after_abort_value", 32'(r), 32'h1000000);

    for (int k = 0; k < 300; k++) begin
      num = 25'($urandom);
      run_op(num, r, lat, bb);
      chk_tol("sweep", real'(r), model(num), 2.0);
    end

    // log2 of the result recovers operands in [1, 2)
    for (int k = 0; k < 40; k++) begin
      num = {2'b01, 23'($urandom)};
      run_op(num, r, lat, bb);
      l = $ln(real'(r) / SC) / $ln(2.0) * SC;
      chk_tol("roundtrip", l, real'(num), 4.0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
